// File: rtl/pi_read_shifter.sv
// pi_read_shifter
// Captures the byte selected by the register-select mux and serialises it to
// the Raspberry Pi. The Pi drives the latch (r_le) and shift clock (r_clk)
// pins. Both pins are asynchronous to clk, so they are synchronised here and
// turned into single-cycle rising-edge pulses before the FSM acts on them.
//
// Timing from a Pi pin edge:
//   - SYNC_STAGES clks through the synchroniser
//   - one more clk for the registered edge pulse
//   - one more clk for the FSM/r_dout update
// The Pi therefore has to hold each r_clk level for at least SYNC_STAGES+2
// clks. SYNC_STAGES is meant to be in the range 2..4.
//
// Bit order: LSB_FIRST=0 shifts bit 7 out first; LSB_FIRST=1 shifts bit 0
// out first.
module pi_read_shifter #(
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] par_in,
  input  logic       r_le,
  input  logic       r_clk,
  output logic       r_dout,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic [3:0] bits_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [SYNC_STAGES-1:0] le_sync;
  logic [SYNC_STAGES-1:0] clk_sync;
  logic                   le_hist;
  logic                   clk_hist;
  logic                   le_rise;
  logic                   clk_rise;

  logic [7:0] sreg;
  logic [7:0] sreg_next;
  logic [7:0] shifted;
  logic [3:0] bits_next;
  logic       dout_next;
  logic       overrun_next;

  // Selects the bit that sits at the output end of a byte.
  function automatic logic out_bit(input logic [7:0] v);
    if (LSB_FIRST) begin
      return v[0];
    end
    return v[7];
  endfunction

  // Pin synchronisers.
  // The edge pulses are registered, which gives the fixed SYNC_STAGES+1
  // pin-to-pulse latency. Only rising edges produce a pulse, so falling edges
  // of both pins are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      le_sync  <= '0;
      clk_sync <= '0;
      le_hist  <= 1'b0;
      clk_hist <= 1'b0;
      le_rise  <= 1'b0;
      clk_rise <= 1'b0;
    end else begin
      le_sync  <= {le_sync[SYNC_STAGES-2:0], r_le};
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], r_clk};
      le_hist  <= le_sync[SYNC_STAGES-1];
      clk_hist <= clk_sync[SYNC_STAGES-1];
      le_rise  <= le_sync[SYNC_STAGES-1] & ~le_hist;
      clk_rise <= clk_sync[SYNC_STAGES-1] & ~clk_hist;
    end
  end

  // Shift register contents after one step toward the output end, zero-filled.
  always_comb begin
    if (LSB_FIRST) begin
      shifted = {1'b0, sreg[7:1]};
    end else begin
      shifted = {sreg[6:0], 1'b0};
    end
  end

  // Next-state and datapath decode.
  // A load always takes priority over a simultaneous shift edge, and in that
  // case the shift edge is simply dropped. The r_dout register is given the
  // output bit of the value sreg is about to hold, so the first bit is
  // visible in the cycle right after the load.
  always_comb begin
    state_next   = state;
    sreg_next    = sreg;
    bits_next    = bits_left;
    dout_next    = r_dout;
    overrun_next = overrun;

    unique case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        dout_next  = 1'b0;
        bits_next  = 4'd0;
        if (le_rise) begin
          sreg_next    = par_in;
          bits_next    = 4'd8;
          dout_next    = out_bit(par_in);
          overrun_next = 1'b0;
          state_next   = SHIFT;
        end else if (clk_rise) begin
          overrun_next = 1'b1;
        end
      end

      SHIFT: begin
        if (le_rise) begin
          sreg_next = par_in;
          bits_next = 4'd8;
          dout_next = out_bit(par_in);
        end else if (clk_rise) begin
          sreg_next = shifted;
          bits_next = bits_left - 4'd1;
          if (bits_left == 4'd1) begin
            state_next = DONE;
            dout_next  = 1'b0;
          end else begin
            dout_next = out_bit(shifted);
          end
        end
      end

      default: begin
        state_next = IDLE;
        dout_next  = 1'b0;
        bits_next  = 4'd0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= 8'd0;
      bits_left <= 4'd0;
      r_dout    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_next;
      sreg      <= sreg_next;
      bits_left <= bits_next;
      r_dout    <= dout_next;
      overrun   <= overrun_next;
    end
  end

  // Status decode.
  // DONE lasts exactly one cycle, so decoding done from the state register
  // gives the single-cycle pulse.
  assign busy = (state == SHIFT);
  assign done = (state == DONE);

endmodule
